// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the hex keypad emulator and scanner.
//   kp_state_t        press-sequence state
//   KEY_ROW/KEY_COL   key code -> matrix row/column (same map the scanner decodes)
//   LFSR_SEED/TAPS    bounce-source LFSR constants, plus lfsr_next() step helper
package keypad_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPressBounce,
    StHold,
    StReleaseBounce,
    StGap
  } kp_state_t;

  // Row 0 = 1 2 3 A, row 1 = 4 5 6 B, row 2 = 7 8 9 C, row 3 = E 0 F D.
  localparam logic [1:0] KEY_ROW [16] = '{
    2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
    2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3
  };
  localparam logic [1:0] KEY_COL [16] = '{
    2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0,
    2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd2
  };

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: key-code handshake between a key producer and the emulator.
//   key_valid  producer -> emulator, key_code is presented
//   key_code   producer -> emulator, hex key to press
//   key_ready  emulator -> producer, high only while idle
interface keypad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_emulator_lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR used as the contact-bounce source.
//   clk_i    clock
//   reset_i  synchronous active-high reset, loads LFSR_SEED
//   q_o      current LFSR value
module lfsr8
  import keypad_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 4x4 hex keypad matrix. An accepted key code is
// played out as press bounce, solid hold, release bounce and an inter-key gap.
//   clk_i      clock (the scanner's clock)
//   reset_i    synchronous active-high reset
//   key_if     key-code handshake (slave side)
//   rows_i     active-low row drive from the scanner
//   columns_o  active-low column sense, combinational from rows_i
//   busy_o     high whenever a press sequence is in progress
//   contact_o  registered switch contact, for debug
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned BounceCycles = 8,
  parameter int unsigned HoldCycles   = 64,
  parameter int unsigned GapCycles    = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  keypad_emulator_if.slave         key_if,
  input  logic               [3:0] rows_i,
  output logic               [3:0] columns_o,
  output logic                     busy_o,
  output logic                     contact_o
);

  localparam int unsigned MaxBh     = (BounceCycles > HoldCycles) ? BounceCycles : HoldCycles;
  localparam int unsigned MaxCycles = (MaxBh > GapCycles) ? MaxBh : GapCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  // Each phase loads N-1 on entry and exits when the counter reads 0, so it lasts N cycles.
  localparam logic [CntW-1:0] BounceLoad = (BounceCycles > 0) ? CntW'(BounceCycles - 1) : '0;
  localparam logic [CntW-1:0] HoldLoad   = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLoad    = CntW'(GapCycles - 1);

  kp_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      kr_q, kr_d;
  logic [1:0]      kc_q, kc_d;
  logic            contact_q, contact_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [7:0]      lfsr_q;
  logic            unused_lfsr;

  lfsr8 u_lfsr8 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .q_o     (lfsr_q)
  );

  // Only bit 0 drives the bounce pattern.
  assign unused_lfsr = ^lfsr_q[7:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    unique case (state_q)
      StIdle: begin
        if (key_if.key_valid && ready_q) begin
          kr_d = KEY_ROW[key_if.key_code];
          kc_d = KEY_COL[key_if.key_code];
          if (BounceCycles != 0) begin
            state_d = StPressBounce;
            cnt_d   = BounceLoad;
          end else begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end
        end
      end
      StPressBounce: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          if (BounceCycles != 0) begin
            state_d = StReleaseBounce;
            cnt_d   = BounceLoad;
          end else begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StReleaseBounce: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the state being entered.
    unique case (state_d)
      StPressBounce, StReleaseBounce: contact_d = lfsr_q[0];
      StHold:                         contact_d = 1'b1;
      default:                        contact_d = 1'b0;
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      kr_q      <= 2'd0;
      kc_q      <= 2'd0;
      contact_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      contact_q <= contact_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Switch matrix: only the pressed key's row, when driven low, pulls its column low.
  always_comb begin
    columns_o = 4'b1111;
    if (contact_q && !rows_i[kr_q]) begin
      columns_o[kc_q] = 1'b0;
    end
  end

  assign key_if.key_ready = ready_q;
  assign busy_o           = busy_q;
  assign contact_o        = contact_q;

endmodule
